// File: rtl/uart_frame_extractor.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_extractor
// Description : Hunts for a programmable header in a received symbol stream,
//               streams out a programmable number of payload symbols and
//               optionally verifies a trailing additive checksum symbol.
//               Re-arms after each frame; optional inter-symbol timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_extractor #(
    parameter int N_BITS         = 8,
    parameter int MAX_HDR        = 16,
    parameter int MAX_PAYLOAD    = 64,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CHECKSUM_EN    = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_BITS-1:0]              char_in,
    input  logic                           char_valid,
    input  logic                           hdr_wr,
    input  logic [$clog2(MAX_HDR)-1:0]     hdr_wr_idx,
    input  logic [N_BITS-1:0]              hdr_wr_data,
    input  logic [$clog2(MAX_HDR):0]       hdr_len,
    input  logic [$clog2(MAX_PAYLOAD):0]   payload_len,
    output logic [N_BITS-1:0]              info_data,
    output logic                           info_valid,
    output logic                           info_last,
    output logic                           frame_ok,
    output logic                           frame_err,
    output logic                           timeout_err,
    output logic                           busy
);

    localparam int IW = $clog2(MAX_HDR);
    localparam int HW = IW + 1;
    localparam int PW = $clog2(MAX_PAYLOAD) + 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [HW-1:0] HDR_MAX = HW'(MAX_HDR);
    localparam logic [HW-1:0] HDR_ONE = HW'(1);
    localparam logic [PW-1:0] PAY_MAX = PW'(MAX_PAYLOAD);
    localparam logic [PW-1:0] PAY_ONE = PW'(1);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_ONE = TW'(1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [N_BITS-1:0]  hdr [MAX_HDR];
    logic [PW-1:0]      plen_q;
    logic [PW-1:0]      cnt;
    logic [N_BITS-1:0]  csum;
    logic [TW-1:0]      tcnt;

    logic [HW-1:0]      hlen_eff;
    logic [PW-1:0]      plen_eff;
    logic [PW-1:0]      cnt_next;
    logic               hdr_hit;
    logic               hdr_first_hit;
    logic               hdr_done;

    // Clamp run-time lengths and decode header matching for the current symbol
    always_comb begin
        hlen_eff      = (hdr_len > HDR_MAX) ? HDR_MAX : hdr_len;
        plen_eff      = (payload_len > PAY_MAX) ? PAY_MAX : payload_len;
        cnt_next      = cnt + PAY_ONE;
        hdr_hit       = (char_in == hdr[idx]);
        hdr_first_hit = (char_in == hdr[0]);
        hdr_done      = ({1'b0, idx} == (hlen_eff - HDR_ONE));
    end

    assign busy = (state != HUNT) || (idx != '0);

    // Header storage; writes land one clock later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_HDR; i++) begin
                hdr[i] <= '0;
            end
        end else if (hdr_wr && ({1'b0, hdr_wr_idx} < HDR_MAX)) begin
            hdr[hdr_wr_idx] <= hdr_wr_data;
        end
    end

    // Frame FSM with registered strobes and timeout handling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            idx         <= '0;
            plen_q      <= '0;
            cnt         <= '0;
            csum        <= '0;
            tcnt        <= '0;
            info_data   <= '0;
            info_valid  <= 1'b0;
            info_last   <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            info_valid  <= 1'b0;
            info_last   <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;

            if (hdr_wr && busy) begin
                // Header changed under a partial frame: silently re-arm
                state <= HUNT;
                idx   <= '0;
                tcnt  <= '0;
            end else if (char_valid) begin
                tcnt <= '0;
                unique case (state)
                    HUNT: begin
                        if (hlen_eff != '0) begin
                            if (hdr_hit) begin
                                if (hdr_done) begin
                                    idx    <= '0;
                                    csum   <= '0;
                                    cnt    <= '0;
                                    plen_q <= plen_eff;
                                    if (plen_eff != '0) begin
                                        state <= PAYLOAD;
                                    end else if (CHECKSUM_EN != 0) begin
                                        state <= CHECK;
                                    end else begin
                                        frame_ok <= 1'b1;
                                        state    <= HUNT;
                                    end
                                end else begin
                                    idx <= idx + 1'b1;
                                end
                            end else begin
                                // Only a restart at header position 0 is considered
                                idx <= hdr_first_hit ? IW'(1) : '0;
                            end
                        end
                    end
                    PAYLOAD: begin
                        info_valid <= 1'b1;
                        info_data  <= char_in;
                        csum       <= csum + char_in;
                        cnt        <= cnt_next;
                        if (cnt_next == plen_q) begin
                            info_last <= 1'b1;
                            if (CHECKSUM_EN != 0) begin
                                state <= CHECK;
                            end else begin
                                frame_ok <= 1'b1;
                                state    <= HUNT;
                            end
                        end
                    end
                    CHECK: begin
                        if (char_in == csum) begin
                            frame_ok <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= HUNT;
                        idx   <= '0;
                    end
                    default: begin
                        state <= HUNT;
                        idx   <= '0;
                    end
                endcase
            end else if ((TIMEOUT_CYCLES > 0) && busy) begin
                if ((tcnt + TMO_ONE) == TMO_LIM) begin
                    timeout_err <= 1'b1;
                    state       <= HUNT;
                    idx         <= '0;
                    tcnt        <= '0;
                end else begin
                    tcnt <= tcnt + TMO_ONE;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_extractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_extractor
// Description : Scoreboard bench for uart_frame_extractor (header "AB",
//               checksum enabled, 20-cycle inter-symbol timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_extractor;

    localparam int K_INFO = 0;
    localparam int K_OK   = 1;
    localparam int K_ERR  = 2;
    localparam int K_TMO  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] char_in;
    logic       char_valid;
    logic       hdr_wr;
    logic [3:0] hdr_wr_idx;
    logic [7:0] hdr_wr_data;
    logic [4:0] hdr_len;
    logic [6:0] payload_len;
    logic [7:0] info_data;
    logic       info_valid;
    logic       info_last;
    logic       frame_ok;
    logic       frame_err;
    logic       timeout_err;
    logic       busy;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       last;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  errors = 0;
    int  checks = 0;

    uart_frame_extractor #(
        .N_BITS        (8),
        .MAX_HDR       (16),
        .MAX_PAYLOAD   (64),
        .TIMEOUT_CYCLES(20),
        .CHECKSUM_EN   (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .hdr_wr     (hdr_wr),
        .hdr_wr_idx (hdr_wr_idx),
        .hdr_wr_data(hdr_wr_data),
        .hdr_len    (hdr_len),
        .payload_len(payload_len),
        .info_data  (info_data),
        .info_valid (info_valid),
        .info_last  (info_last),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Output monitor: every strobe must match the next scoreboard entry
    always @(negedge clk) begin : mon
        logic s;
        if (info_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_info: unexpected info data=%02h last=%0b", info_data, info_last);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.kind !== K_INFO || mon_e.data !== info_data || mon_e.last !== info_last) begin
                    errors++;
                    $display("FAIL sb_info: got info data=%02h last=%0b, expected kind=%0d data=%02h last=%0b",
                             info_data, info_last, mon_e.kind, mon_e.data, mon_e.last);
                end
            end
        end
        for (int k = K_OK; k <= K_TMO; k++) begin
            s = (k == K_OK) ? frame_ok : (k == K_ERR) ? frame_err : timeout_err;
            if (s) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_event: unexpected event kind=%0d", k);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.kind !== k) begin
                        errors++;
                        $display("FAIL sb_event: got kind=%0d, expected kind=%0d", k, mon_e.kind);
                    end
                end
            end
        end
    end

    task automatic push(input int kind, input logic [7:0] data, input logic last);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.last = last;
        sb.push_back(e);
    endtask

    // Called at posedge+1; strobe is captured by the next posedge
    task automatic send(input logic [7:0] b);
        char_in    = b;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic prog_hdr_ab();
        hdr_wr      = 1'b1;
        hdr_wr_idx  = 4'd0;
        hdr_wr_data = 8'h41;
        @(posedge clk);
        #1;
        hdr_wr_idx  = 4'd1;
        hdr_wr_data = 8'h42;
        @(posedge clk);
        #1;
        hdr_wr      = 1'b0;
    endtask

    task automatic drain(input string name);
        idle(3);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected events never seen, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #17;
        checks++;
        if ({info_valid, info_last, frame_ok, frame_err, timeout_err, busy} !== 6'b0 || info_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: strobes=%06b data=%02h, required 000000 00",
                     {info_valid, info_last, frame_ok, frame_err, timeout_err, busy}, info_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic_frame();
        prog_hdr_ab();
        hdr_len     = 5'd2;
        payload_len = 7'd2;
        push(K_INFO, 8'h10, 1'b0);
        push(K_INFO, 8'h20, 1'b1);
        push(K_OK, 8'h00, 1'b0);
        send(8'h41);
        send(8'h42);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%0b, required 1", busy);
        end
        send(8'h10);
        send(8'h20);
        checks++;
        if (info_last !== 1'b1) begin
            errors++;
            $display("FAIL basic_last: info_last=%0b, required 1", info_last);
        end
        send(8'h30);
        checks++;
        if (frame_ok !== 1'b1 || info_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_ok: frame_ok=%0b info_valid=%0b, required 1 0", frame_ok, info_valid);
        end
        drain("basic");
    endtask

    task automatic test_bad_checksum();
        push(K_INFO, 8'h10, 1'b0);
        push(K_INFO, 8'h20, 1'b1);
        push(K_ERR, 8'h00, 1'b0);
        send(8'h41); send(8'h42); send(8'h10); send(8'h20); send(8'h31);
        checks++;
        if (frame_err !== 1'b1 || frame_ok !== 1'b0) begin
            errors++;
            $display("FAIL badsum_err: frame_err=%0b frame_ok=%0b, required 1 0", frame_err, frame_ok);
        end
        push(K_INFO, 8'h01, 1'b0);
        push(K_INFO, 8'h02, 1'b1);
        push(K_OK, 8'h00, 1'b0);
        send(8'h41); send(8'h42); send(8'h01); send(8'h02); send(8'h03);
        drain("badsum");
    endtask

    task automatic test_restart();
        push(K_INFO, 8'h05, 1'b0);
        push(K_INFO, 8'h06, 1'b1);
        push(K_OK, 8'h00, 1'b0);
        send(8'h41); send(8'h41); send(8'h42); send(8'h05); send(8'h06); send(8'h0B);
        drain("restart");
    endtask

    task automatic test_back_to_back();
        // Two frames with no gap; first symbol after the check is header position 0
        push(K_INFO, 8'hFF, 1'b0);
        push(K_INFO, 8'h02, 1'b1);
        push(K_OK, 8'h00, 1'b0);
        push(K_INFO, 8'h41, 1'b0);
        push(K_INFO, 8'h42, 1'b1);
        push(K_OK, 8'h00, 1'b0);
        send(8'h41); send(8'h42); send(8'hFF); send(8'h02); send(8'h01);
        send(8'h41); send(8'h42); send(8'h41); send(8'h42); send(8'h83);
        drain("b2b");
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        push(K_INFO, 8'h10, 1'b0);
        push(K_TMO, 8'h00, 1'b0);
        send(8'h41); send(8'h42); send(8'h10);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (timeout_err === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== 20) begin
            errors++;
            $display("FAIL timeout_delay: timeout_err after %0d clks (0=never), required 20", n);
        end
        idle(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_busy: busy=%0b, required 0", busy);
        end
        push(K_INFO, 8'h01, 1'b0);
        push(K_INFO, 8'h02, 1'b1);
        push(K_OK, 8'h00, 1'b0);
        send(8'h41); send(8'h42); send(8'h01); send(8'h02); send(8'h03);
        drain("timeout");
    endtask

    task automatic test_hdr_wr_abort();
        send(8'h41);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL hdrwr_busy_pre: busy=%0b, required 1", busy);
        end
        hdr_wr      = 1'b1;
        hdr_wr_idx  = 4'd0;
        hdr_wr_data = 8'h41;
        char_in     = 8'h42;
        char_valid  = 1'b1;
        @(posedge clk);
        #1;
        hdr_wr     = 1'b0;
        char_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hdrwr_abort: busy=%0b, required 0", busy);
        end
        push(K_INFO, 8'h01, 1'b0);
        push(K_INFO, 8'h02, 1'b1);
        push(K_OK, 8'h00, 1'b0);
        send(8'h41); send(8'h42); send(8'h01); send(8'h02); send(8'h03);
        drain("hdrwr");
    endtask

    task automatic test_hdr_len_zero();
        hdr_len = 5'd0;
        send(8'h41); send(8'h42); send(8'h10); send(8'h20); send(8'h30);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hlen0_busy: busy=%0b, required 0", busy);
        end
        drain("hlen0");
        hdr_len = 5'd2;
    endtask

    task automatic test_payload_zero();
        payload_len = 7'd0;
        push(K_OK, 8'h00, 1'b0);
        send(8'h41); send(8'h42);
        send(8'h00);
        checks++;
        if (frame_ok !== 1'b1) begin
            errors++;
            $display("FAIL plen0_ok: frame_ok=%0b, required 1", frame_ok);
        end
        drain("plen0");
        payload_len = 7'd2;
    endtask

    task automatic test_async_reset();
        send(8'h41); send(8'h42); send(8'h10);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (info_valid !== 1'b0 || info_data !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_outputs: info_valid=%0b info_data=%02h busy=%0b, required 0 00 0",
                     info_valid, info_data, busy);
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        // Cleared header storage now matches 00 00
        payload_len = 7'd1;
        push(K_INFO, 8'h07, 1'b1);
        push(K_OK, 8'h00, 1'b0);
        send(8'h00); send(8'h00); send(8'h07); send(8'h07);
        drain("areset_clr");
        prog_hdr_ab();
        payload_len = 7'd2;
        push(K_INFO, 8'h11, 1'b0);
        push(K_INFO, 8'h22, 1'b1);
        push(K_OK, 8'h00, 1'b0);
        send(8'h41); send(8'h42); send(8'h11); send(8'h22); send(8'h33);
        drain("areset_frame");
    endtask

    initial begin
        char_in     = '0;
        char_valid  = 1'b0;
        hdr_wr      = 1'b0;
        hdr_wr_idx  = '0;
        hdr_wr_data = '0;
        hdr_len     = '0;
        payload_len = '0;
        test_reset();
        test_basic_frame();
        test_bad_checksum();
        test_restart();
        test_back_to_back();
        test_timeout();
        test_hdr_wr_abort();
        test_hdr_len_zero();
        test_payload_zero();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_extractor.md
Name: uart_frame_extractor

Overview:
Byte-stream frame extractor that sits behind the UART receiver. It hunts for a runtime-programmable header of 1..MAX_HDR symbols, then streams out a runtime-programmable number of payload symbols. An optional additive checksum symbol is verified after the payload. The block re-arms automatically after every frame, and an inter-symbol timeout aborts stalled frames.

Parameters:
N_BITS, 8, symbol width
MAX_HDR, 16, header storage depth (>=2)
MAX_PAYLOAD, 64, maximum payload symbols per frame (>=1)
TIMEOUT_CYCLES, 0, idle clocks between symbols before a partial frame is aborted; 0 disables the timeout
CHECKSUM_EN, 1, 1 = one checksum symbol follows the payload

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
char_in  in  N_BITS  received symbol
char_valid  in  1  single-cycle strobe, char_in valid
hdr_wr  in  1  write strobe for header storage
hdr_wr_idx  in  $clog2(MAX_HDR)  header position to write
hdr_wr_data  in  N_BITS  header symbol value
hdr_len  in  $clog2(MAX_HDR)+1  active header length; 0 = extractor disabled
payload_len  in  $clog2(MAX_PAYLOAD)+1  payload symbols per frame
info_data  out  N_BITS  payload symbol
info_valid  out  1  info_data strobe
info_last  out  1  high with the final payload symbol
frame_ok  out  1  pulse: frame complete, checksum good or disabled
frame_err  out  1  pulse: checksum mismatch
timeout_err  out  1  pulse: partial frame aborted by timeout
busy  out  1  high whenever the state is not HUNT with match index 0

Behaviour:
- Reset (async, rst_n low): state HUNT, match index 0, header storage all 0. All outputs 0, including info_data. Timeout counter 0, checksum accumulator 0.
- Outputs are registered and update 1 clk after the qualifying char_valid. Output strobes are 1-cycle pulses.
- HUNT, hdr_len=0: all symbols are ignored.
- HUNT, symbol equals hdr[idx]: idx increments.
- HUNT, match at idx = hdr_len-1: go to PAYLOAD, clear the checksum, latch payload_len into plen_q.
  - If plen_q = 0: go straight to CHECK (CHECKSUM_EN=1), or pulse frame_ok and return to HUNT (CHECKSUM_EN=0).
- HUNT, mismatch: idx becomes 1 if the symbol equals hdr[0], else 0 (single-symbol restart; no general overlap search).
- PAYLOAD: each symbol produces info_valid=1 and info_data=symbol, and is added to the checksum (sum mod 2^N_BITS). The count increments. info_last=1 on symbol number plen_q.
  - After the last symbol: go to CHECK (CHECKSUM_EN=1), or pulse frame_ok with info_last and return to HUNT.
- CHECK: the next symbol is compared to the checksum. Equal pulses frame_ok, otherwise frame_err. The state returns to HUNT with idx 0. The check symbol is never emitted on info_data.
- A payload_len above MAX_PAYLOAD is clamped to MAX_PAYLOAD at latch time. An hdr_len above MAX_HDR is treated as MAX_HDR.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter clears on every char_valid and counts while busy=1.
  - On reaching TIMEOUT_CYCLES: pulse timeout_err, go to HUNT with idx 0.
  - A char_valid in the same cycle wins; no timeout fires that cycle.
- Header write (hdr_wr):
  - Takes effect next clk. Writes are allowed at any time.
  - A write while busy=1 also aborts to HUNT with idx 0 and no error pulse. That cycle's char_valid is discarded.
- hdr_len and payload_len must be held stable in HUNT. A change while busy is not detected. payload_len is used only via plen_q.
- Frames may be back-to-back with no gap: the symbol after CHECK (or after the last payload symbol) is evaluated as header position 0.

Test Plan:
- Header "AB" (0x41,0x42), hdr_len=2, payload_len=2, checksum on. Send 41 42 10 20 30 -> info_valid twice with data 10 then 20 (info_last on 20), then frame_ok one clk after 30.
- Same setup, send 41 42 10 20 31 -> two payload outputs, then frame_err and no frame_ok. The next frame 41 42 01 02 03 -> frame_ok.
- Send 41 41 42 05 06 0B -> the restart rule matches the header starting at the second 41 -> outputs 05, 06, frame_ok.
- TIMEOUT_CYCLES=20: send 41 42 10, then idle 20 clks -> timeout_err exactly 20 clks after the last strobe, busy drops. A following 41 42 01 02 03 frame -> frame_ok.
- Drop rst_n mid-payload after 41 42 10 -> outputs 0 immediately (asynchronously) and header storage cleared. After reprogramming the header, a full frame extracts normally.
- hdr_len=0 with any stream -> no outputs. payload_len=0 with checksum on: 41 42 00 -> frame_ok with no info_valid.
